// File: rtl/vga_image_scanner_if.sv
// Signal bundle between the VGA image scanner, its image memory and the display side.
interface vga_image_scanner_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned PIX_W  = 8
);
    logic              src_sel;
    logic [PIX_W-1:0]  pix_raw;
    logic [PIX_W-1:0]  pix_dec;
    logic [ADDR_W-1:0] img_addr;
    logic              Hsync;
    logic              Vsync;
    logic [7:0]        Red;
    logic [7:0]        Green;
    logic [7:0]        Blue;
    logic              de;
    logic              frame_start;

    modport master (
        input  src_sel, pix_raw, pix_dec,
        output img_addr, Hsync, Vsync, Red, Green, Blue, de, frame_start
    );

    modport slave (
        output src_sel, pix_raw, pix_dec,
        input  img_addr, Hsync, Vsync, Red, Green, Blue, de, frame_start
    );
endinterface

// File: rtl/vga_image_scanner.sv
// Parametrised VGA timing generator that scans an image window from memory with latency compensation.
// Optional macro VGA_IMAGE_SCANNER_BORDER_EN draws a white 1-pixel ring around the image window.
module vga_image_scanner #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned SYNC_POL = 0,
    parameter int unsigned X0       = 0,
    parameter int unsigned Y0       = 0,
    parameter int unsigned IMG_W    = 256,
    parameter int unsigned IMG_H    = 256,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned MEM_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    vga_image_scanner_if.master vga
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;
    localparam logic        ACT_LVL = 1'(SYNC_POL);

    typedef struct packed {
        logic fs;
        logic ring;
        logic win;
        logic de;
        logic vs;
        logic hs;
    } stage_t;

    if (X0 + IMG_W > H_ACTIVE) begin : g_chk_x
        $fatal(1, "image window exceeds active width");
    end
    if (Y0 + IMG_H > V_ACTIVE) begin : g_chk_y
        $fatal(1, "image window exceeds active height");
    end
    if (64'(IMG_W) * 64'(IMG_H) > (64'd1 << ADDR_W)) begin : g_chk_addr
        $fatal(1, "image does not fit the address width");
    end
    if (MEM_LAT < 1) begin : g_chk_lat
        $fatal(1, "memory latency must be at least one cycle");
    end

    function automatic logic in_win(input int unsigned h, input int unsigned v);
        return (h + 32'd1 > X0) && (h < X0 + IMG_W) && (v + 32'd1 > Y0) && (v < Y0 + IMG_H);
    endfunction

    logic [H_W-1:0]    r_h_cnt;
    logic [V_W-1:0]    r_v_cnt;
    logic [H_W-1:0]    w_h_nxt;
    logic [V_W-1:0]    w_v_nxt;
    logic              w_h_last;
    logic              w_v_last;
    int unsigned       w_h;
    int unsigned       w_v;
    logic              w_win;
    logic              w_win_nxt;
    logic              w_frame_nxt;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic [ADDR_W-1:0] r_img_addr;
    logic [ADDR_W-1:0] w_cnt_after;
    logic              r_sel;
    stage_t            w_stage;
    stage_t            r_pipe [MEM_LAT];
    stage_t            w_out;
    logic [PIX_W-1:0]  w_pix_sel;
    logic [7:0]        w_pix8;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_de;
    logic              r_fs;
    logic [7:0]        r_pix;

    // Raster position counters
    assign w_h_last = (r_h_cnt == H_W'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == V_W'(V_TOTAL - 1));
    assign w_h_nxt  = w_h_last ? '0 : r_h_cnt + H_W'(1);
    assign w_v_nxt  = w_h_last ? (w_v_last ? '0 : r_v_cnt + V_W'(1)) : r_v_cnt;
    assign w_h      = 32'(r_h_cnt);
    assign w_v      = 32'(r_v_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
        end
    end

    // Address is computed one position ahead so img_addr is a register aligned with the counters
    assign w_win       = in_win(w_h, w_v);
    assign w_win_nxt   = in_win(32'(w_h_nxt), 32'(w_v_nxt));
    assign w_frame_nxt = (w_h_nxt == '0) && (w_v_nxt == '0);
    assign w_cnt_after = w_win ? r_addr_cnt + ADDR_W'(1) : r_addr_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_frame_nxt) begin
            r_addr_cnt <= '0;
            r_img_addr <= '0;
        end else begin
            r_addr_cnt <= w_cnt_after;
            if (w_win_nxt) begin
                r_img_addr <= w_cnt_after;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= 1'b0;
        end else if ((r_h_cnt == '0) && (r_v_cnt == '0)) begin
            r_sel <= vga.src_sel;
        end
    end

    always_comb begin
        w_stage      = '0;
        w_stage.hs   = (w_h >= HS_BEG) && (w_h < HS_END);
        w_stage.vs   = (w_v >= VS_BEG) && (w_v < VS_END);
        w_stage.de   = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
        w_stage.win  = w_win;
        w_stage.fs   = (r_h_cnt == '0) && (r_v_cnt == '0);
`ifdef VGA_IMAGE_SCANNER_BORDER_EN
        // Ring columns/rows are tested with +1/+2 offsets so X0=0 or Y0=0 needs no signed math
        w_stage.ring = w_stage.de &&
            ((((w_h + 32'd1 == X0) || (w_h == X0 + IMG_W)) &&
              (w_v + 32'd2 > Y0) && (w_v <= Y0 + IMG_H)) ||
             (((w_v + 32'd1 == Y0) || (w_v == Y0 + IMG_H)) &&
              (w_h + 32'd2 > X0) && (w_h <= X0 + IMG_W)));
`endif
    end

    // Delay the position flags to match the memory read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_stage;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_out     = r_pipe[MEM_LAT-1];
    assign w_pix_sel = r_sel ? vga.pix_dec : vga.pix_raw;

    if (PIX_W >= 8) begin : g_pix_trunc
        assign w_pix8 = w_pix_sel[PIX_W-1 -: 8];
    end else begin : g_pix_ext
        assign w_pix8 = {w_pix_sel, (8 - PIX_W)'(0)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync <= ~ACT_LVL;
            r_vsync <= ~ACT_LVL;
            r_de    <= 1'b0;
            r_fs    <= 1'b0;
            r_pix   <= '0;
        end else begin
            r_hsync <= w_out.hs ? ACT_LVL : ~ACT_LVL;
            r_vsync <= w_out.vs ? ACT_LVL : ~ACT_LVL;
            r_de    <= w_out.de;
            r_fs    <= w_out.fs;
            if (w_out.win) begin
                r_pix <= w_pix8;
            end else if (w_out.ring) begin
                r_pix <= 8'hFF;
            end else begin
                r_pix <= '0;
            end
        end
    end

    assign vga.img_addr    = r_img_addr;
    assign vga.Hsync       = r_hsync;
    assign vga.Vsync       = r_vsync;
    assign vga.de          = r_de;
    assign vga.frame_start = r_fs;
    assign vga.Red         = r_pix;
    assign vga.Green       = r_pix;
    assign vga.Blue        = r_pix;
endmodule

// File: tb/tb_vga_image_scanner.sv
// Randomized self-checking bench: two scanner configurations on a reduced raster against a position-based model.
module tb_vga_image_scanner;
    localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4, HT = HA + HFP + HSW + HBP;
    localparam int VA = 40, VFP = 2, VSW = 2, VBP = 3, VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;

    localparam int A_X0 = 0,  A_Y0 = 0, A_W = 32, A_H = 32, A_LAT = 1, A_POL = 0, A_PW = 8, A_AW = 10;
    localparam int B_X0 = 10, B_Y0 = 5, B_W = 20, B_H = 12, B_LAT = 3, B_POL = 1, B_PW = 4, B_AW = 8;

    logic       clk;
    logic       rst;
    logic       src;
    int         k;
    int         n_checks;
    int         n_pass;
    int         last_fs_a;
    int         last_fs_b;
    logic       sel_hist [16384];
    logic [7:0] key_a;
    logic [3:0] key_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_image_scanner_if #(.ADDR_W(A_AW), .PIX_W(A_PW)) bus_a ();
    vga_image_scanner_if #(.ADDR_W(B_AW), .PIX_W(B_PW)) bus_b ();

    vga_image_scanner #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(A_POL), .X0(A_X0), .Y0(A_Y0), .IMG_W(A_W), .IMG_H(A_H),
        .ADDR_W(A_AW), .PIX_W(A_PW), .MEM_LAT(A_LAT)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .vga (bus_a)
    );

    vga_image_scanner #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(B_POL), .X0(B_X0), .Y0(B_Y0), .IMG_W(B_W), .IMG_H(B_H),
        .ADDR_W(B_AW), .PIX_W(B_PW), .MEM_LAT(B_LAT)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .vga (bus_b)
    );

    // Image memories: data is the low bits of the address read MEM_LAT cycles earlier
    logic [A_AW-1:0] mem_a_q;
    logic [B_AW-1:0] mem_b_q [B_LAT];

    always @(posedge clk) begin
        mem_a_q    <= bus_a.img_addr;
        mem_b_q[0] <= bus_b.img_addr;
        for (int i = 1; i < B_LAT; i++) mem_b_q[i] <= mem_b_q[i-1];
    end

    assign bus_a.src_sel = src;
    assign bus_a.pix_raw = mem_a_q[7:0];
    assign bus_a.pix_dec = mem_a_q[7:0] ^ key_a;
    assign bus_b.src_sel = src;
    assign bus_b.pix_raw = mem_b_q[B_LAT-1][3:0];
    assign bus_b.pix_dec = mem_b_q[B_LAT-1][3:0] ^ key_b;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    endtask

    // Address on the bus at raster index p: last window pixel issued so far this frame, else 0
    function automatic logic [31:0] exp_addr(input int p, input int x0, input int y0, input int w, input int h);
        int pm, hh, vv, n, c;
        pm = p % FRAME;
        hh = pm % HT;
        vv = pm / HT;
        if (vv < y0) n = 0;
        else if (vv >= y0 + h) n = w * h;
        else begin
            c = hh - x0 + 1;
            if (c < 0) c = 0;
            if (c > w) c = w;
            n = (vv - y0) * w + c;
        end
        return (n == 0) ? 32'd0 : 32'(n - 1);
    endfunction

`ifdef VGA_IMAGE_SCANNER_BORDER_EN
    function automatic bit on_ring(input int hh, input int vv, input int x0, input int y0, input int w, input int h);
        return ((hh == x0 - 1 || hh == x0 + w) && vv >= y0 - 1 && vv <= y0 + h) ||
               ((vv == y0 - 1 || vv == y0 + h) && hh >= x0 - 1 && hh <= x0 + w);
    endfunction
`endif

    task automatic check_dut(input string name, input int lat, input int pol,
                             input int x0, input int y0, input int w, input int h,
                             input int pw, input logic [7:0] key,
                             input logic hs_g, input logic vs_g, input logic de_g, input logic fs_g,
                             input logic [23:0] rgb_g, input logic [31:0] addr_g,
                             inout int last_fs);
        int p, pm, hh, vv, idx, val;
        logic e_hs, e_vs, e_de, e_fs;
        logic [7:0] e_pix;
        e_hs  = (pol == 0);
        e_vs  = (pol == 0);
        e_de  = 1'b0;
        e_fs  = 1'b0;
        e_pix = 8'h00;
        if (k >= lat + 1) begin
            p  = k - lat - 1;
            pm = p % FRAME;
            hh = pm % HT;
            vv = pm / HT;
            if (hh >= HA + HFP && hh < HA + HFP + HSW) e_hs = (pol != 0);
            if (vv >= VA + VFP && vv < VA + VFP + VSW) e_vs = (pol != 0);
            e_de = (hh < HA) && (vv < VA);
            e_fs = (pm == 0);
            if (hh >= x0 && hh < x0 + w && vv >= y0 && vv < y0 + h) begin
                idx   = (vv - y0) * w + (hh - x0);
                val   = sel_hist[p - pm] ? (idx ^ int'(key)) : idx;
                val   = val & ((1 << pw) - 1);
                e_pix = 8'(val << (8 - pw));
            end
`ifdef VGA_IMAGE_SCANNER_BORDER_EN
            else if (e_de && on_ring(hh, vv, x0, y0, w, h)) e_pix = 8'hFF;
`endif
        end
        check_eq({name, ".hsync"}, 32'(hs_g), 32'(e_hs));
        check_eq({name, ".vsync"}, 32'(vs_g), 32'(e_vs));
        check_eq({name, ".de"}, 32'(de_g), 32'(e_de));
        check_eq({name, ".frame_start"}, 32'(fs_g), 32'(e_fs));
        check_eq({name, ".rgb"}, 32'(rgb_g), 32'({e_pix, e_pix, e_pix}));
        check_eq({name, ".img_addr"}, addr_g, exp_addr(k, x0, y0, w, h));
        if (fs_g === 1'b1) begin
            if (last_fs >= 0) check_eq({name, ".fs_period"}, 32'(k - last_fs), 32'(FRAME));
            last_fs = k;
        end
    endtask

    task automatic check_all();
        check_dut("A", A_LAT, A_POL, A_X0, A_Y0, A_W, A_H, A_PW, key_a,
                  bus_a.Hsync, bus_a.Vsync, bus_a.de, bus_a.frame_start,
                  {bus_a.Red, bus_a.Green, bus_a.Blue}, 32'(bus_a.img_addr), last_fs_a);
        check_dut("B", B_LAT, B_POL, B_X0, B_Y0, B_W, B_H, B_PW, {4'h0, key_b},
                  bus_b.Hsync, bus_b.Vsync, bus_b.de, bus_b.frame_start,
                  {bus_b.Red, bus_b.Green, bus_b.Blue}, 32'(bus_b.img_addr), last_fs_b);
    endtask

    // k counts non-reset edges since the last reset edge, i.e. the raster index of the counters
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            k         = 0;
            last_fs_a = -1;
            last_fs_b = -1;
        end else begin
            k++;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic run_to(input int k_end, input bit rand_sel);
        while (k < k_end) begin
            cycle();
            if (rand_sel && $urandom_range(0, 299) == 0) src = ~src;
            sel_hist[k] = src;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        k         = 0;
        last_fs_a = -1;
        last_fs_b = -1;
        key_a     = 8'($urandom_range(1, 255));
        key_b     = 4'($urandom_range(1, 15));
        src       = 1'b0;
        rst       = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        sel_hist[k] = src;

        // Mid-frame select change only takes effect from the next frame
        run_to(20 * HT, 1'b0);
        src = 1'b1;
        sel_hist[k] = src;
        run_to(FRAME + 10 * HT, 1'b0);
        run_to(2 * FRAME + 30 * HT, 1'b1);

        // One-cycle reset in the middle of a frame
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sel_hist[k] = src;
        run_to(FRAME + 200, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
